// File: rtl/multicycle_control_if.sv
// multicycle_control_if: handshake, opcode and control-strobe bundle between the
// multicycle sequencer (slave) and its environment (master).
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [6:0]       opcode;
    logic             branch_taken;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_write;
    logic             dmem_req;
    logic             dmem_we;
    logic [1:0]       alu_op;
    logic             alu_src_imm;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             pc_write;
    logic             pc_sel;
    logic             busy;
    logic             trap;
    logic [CNT_W-1:0] instret;

    modport master (
        output run, opcode, branch_taken, imem_ready, dmem_ready,
        input  imem_req, ir_write, dmem_req, dmem_we, alu_op, alu_src_imm,
               reg_write, wb_sel, pc_write, pc_sel, busy, trap, instret
    );

    modport slave (
        input  run, opcode, branch_taken, imem_ready, dmem_ready,
        output imem_req, ir_write, dmem_req, dmem_we, alu_op, alu_src_imm,
               reg_write, wb_sel, pc_write, pc_sel, busy, trap, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/memory/writeback sequencer for the multi-cycle RISC-V core.
// Define ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_control_if.slave  bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_JUMP
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    typedef enum logic [2:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_ILL} cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t           state_q, state_d, retire_nxt;
    cls_t             cls_q, cls_d, dec;
    logic [CNT_W-1:0] instret_q;
    logic             imem_req, ir_write, dmem_req, dmem_we, alu_src_imm;
    logic             reg_write, pc_write, pc_sel;
    logic [1:0]       alu_op, wb_sel;

    always_comb begin
        dec = bus.opcode == OP_R      ? C_R      :
              bus.opcode == OP_I      ? C_I      :
              bus.opcode == OP_LOAD   ? C_LOAD   :
              bus.opcode == OP_STORE  ? C_STORE  :
              bus.opcode == OP_BRANCH ? C_BRANCH :
              bus.opcode == OP_JAL    ? C_JAL    : C_ILL;
        cls_d      = state_q == S_DECODE ? dec : cls_q;
        retire_nxt = bus.run ? S_FETCH : S_IDLE;
    end

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_op      = 2'b00;
        alu_src_imm = 1'b0;
        reg_write   = 1'b0;
        wb_sel      = 2'b00;
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        case (state_q)
            S_IDLE: state_d = bus.run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = bus.imem_ready;
                state_d  = bus.imem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (dec)
                    C_BRANCH: state_d = S_BRANCH;
                    C_JAL:    state_d = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    C_ILL:    state_d = S_TRAP;
`else
                    C_ILL: begin
                        pc_write = 1'b1;
                        state_d  = retire_nxt;
                    end
`endif
                    default:  state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_op      = cls_q == C_R ? 2'b10 : 2'b00;
                alu_src_imm = cls_q != C_R;
                state_d     = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                alu_src_imm = 1'b1;
                dmem_req    = 1'b1;
                dmem_we     = cls_q == C_STORE;
                pc_write    = bus.dmem_ready && cls_q == C_STORE;
                state_d     = !bus.dmem_ready ? S_MEM : cls_q == C_STORE ? retire_nxt : S_WB;
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = cls_q == C_LOAD ? 2'b01 : 2'b00;
                pc_write  = 1'b1;
                state_d   = retire_nxt;
            end
            S_BRANCH: begin
                alu_op   = 2'b01;
                pc_write = 1'b1;
                pc_sel   = bus.branch_taken;
                state_d  = retire_nxt;
            end
            S_JUMP: begin
                alu_op    = 2'b11;
                reg_write = 1'b1;
                wb_sel    = 2'b10;
                pc_write  = 1'b1;
                pc_sel    = 1'b1;
                state_d   = retire_nxt;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_ILL;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            if (pc_write) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign bus.imem_req    = imem_req;
    assign bus.ir_write    = ir_write;
    assign bus.dmem_req    = dmem_req;
    assign bus.dmem_we     = dmem_we;
    assign bus.alu_op      = alu_op;
    assign bus.alu_src_imm = alu_src_imm;
    assign bus.reg_write   = reg_write;
    assign bus.wb_sel      = wb_sel;
    assign bus.pc_write    = pc_write;
    assign bus.pc_sel      = pc_sel;
    assign bus.busy        = state_q != S_IDLE;
    assign bus.instret     = instret_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus.trap        = state_q == S_TRAP;
`else
    assign bus.trap        = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed-vector bench for multicycle_control with a 4-bit retire counter.
// Output vectors pack {imem_req,ir_write,dmem_req,dmem_we,alu_op,alu_src_imm,reg_write,wb_sel,pc_write,pc_sel,busy,trap}.
module tb_multicycle_control;
    localparam int CNT_W = 4;

    localparam logic [13:0] V_IDLE    = 14'b0_0_0_0_00_0_0_00_0_0_0_0;
    localparam logic [13:0] V_FWAIT   = 14'b1_0_0_0_00_0_0_00_0_0_1_0;
    localparam logic [13:0] V_FRDY    = 14'b1_1_0_0_00_0_0_00_0_0_1_0;
    localparam logic [13:0] V_DEC     = 14'b0_0_0_0_00_0_0_00_0_0_1_0;
    localparam logic [13:0] V_EXR     = 14'b0_0_0_0_10_0_0_00_0_0_1_0;
    localparam logic [13:0] V_EXI     = 14'b0_0_0_0_00_1_0_00_0_0_1_0;
    localparam logic [13:0] V_MEMLD   = 14'b0_0_1_0_00_1_0_00_0_0_1_0;
    localparam logic [13:0] V_MEMSTW  = 14'b0_0_1_1_00_1_0_00_0_0_1_0;
    localparam logic [13:0] V_MEMSTR  = 14'b0_0_1_1_00_1_0_00_1_0_1_0;
    localparam logic [13:0] V_WBALU   = 14'b0_0_0_0_00_0_1_00_1_0_1_0;
    localparam logic [13:0] V_WBLD    = 14'b0_0_0_0_00_0_1_01_1_0_1_0;
    localparam logic [13:0] V_BRT     = 14'b0_0_0_0_01_0_0_00_1_1_1_0;
    localparam logic [13:0] V_BRNT    = 14'b0_0_0_0_01_0_0_00_1_0_1_0;
    localparam logic [13:0] V_JUMP    = 14'b0_0_0_0_11_0_1_10_1_1_1_0;
    localparam logic [13:0] V_DECNOP  = 14'b0_0_0_0_00_0_0_00_1_0_1_0;
    localparam logic [13:0] V_TRAP    = 14'b0_0_0_0_00_0_0_00_0_0_1_1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pw = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();
    multicycle_control #(.CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    logic [13:0] outv;
    assign outv = {bus.imem_req, bus.ir_write, bus.dmem_req, bus.dmem_we, bus.alu_op, bus.alu_src_imm,
                   bus.reg_write, bus.wb_sel, bus.pc_write, bus.pc_sel, bus.busy, bus.trap};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [13:0] exp);
        #1;
        chk(tag, {18'd0, outv}, {18'd0, exp});
        chk({tag, "_excl"}, {31'd0, bus.imem_req & bus.dmem_req}, 32'd0);
        if (bus.pc_write === 1'b1) pw++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.run = 1'b0;
        bus.opcode = 7'd0;
        bus.branch_taken = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_out", {18'd0, outv}, {18'd0, V_IDLE});
        chk("rst_instret", {28'd0, bus.instret}, 32'd0);

        bus.run = 1'b1;
        bus.imem_ready = 1'b1;
        bus.opcode = 7'b0110011;
        cyc("r_idle", V_IDLE);
        cyc("r_fetch", V_FRDY);
        cyc("r_dec", V_DEC);
        cyc("r_exec", V_EXR);
        cyc("r_wb", V_WBALU);
        chk("r_instret", {28'd0, bus.instret}, 32'd1);

        pw = 0;
        bus.opcode = 7'b0000011;
        cyc("ld_fetch", V_FRDY);
        cyc("ld_dec", V_DEC);
        cyc("ld_exec", V_EXI);
        bus.dmem_ready = 1'b0;
        cyc("ld_mem_w1", V_MEMLD);
        cyc("ld_mem_w2", V_MEMLD);
        cyc("ld_mem_w3", V_MEMLD);
        bus.dmem_ready = 1'b1;
        cyc("ld_mem_rdy", V_MEMLD);
        bus.dmem_ready = 1'b0;
        cyc("ld_wb", V_WBLD);
        chk("ld_pc_writes", pw, 32'd1);
        chk("ld_instret", {28'd0, bus.instret}, 32'd2);

        bus.opcode = 7'b0100011;
        cyc("st_fetch", V_FRDY);
        cyc("st_dec", V_DEC);
        cyc("st_exec", V_EXI);
        cyc("st_mem_w", V_MEMSTW);
        bus.dmem_ready = 1'b1;
        cyc("st_mem_rdy", V_MEMSTR);
        bus.dmem_ready = 1'b0;
        chk("st_instret", {28'd0, bus.instret}, 32'd3);

        bus.opcode = 7'b1100011;
        bus.branch_taken = 1'b1;
        cyc("bt_fetch", V_FRDY);
        cyc("bt_dec", V_DEC);
        cyc("bt_br", V_BRT);
        bus.branch_taken = 1'b0;
        cyc("bn_fetch", V_FRDY);
        cyc("bn_dec", V_DEC);
        cyc("bn_br", V_BRNT);
        chk("br_instret", {28'd0, bus.instret}, 32'd5);

        bus.opcode = 7'b1101111;
        bus.imem_ready = 1'b0;
        cyc("j_fetch_w1", V_FWAIT);
        cyc("j_fetch_w2", V_FWAIT);
        bus.imem_ready = 1'b1;
        cyc("j_fetch", V_FRDY);
        bus.run = 1'b0;
        cyc("j_dec", V_DEC);
        cyc("j_jump", V_JUMP);
        cyc("j_idle", V_IDLE);
        chk("j_busy", {31'd0, bus.busy}, 32'd0);
        chk("j_instret", {28'd0, bus.instret}, 32'd6);

        bus.run = 1'b1;
        bus.opcode = 7'b0010011;
        cyc("i_idle", V_IDLE);
        cyc("i_fetch", V_FRDY);
        cyc("i_dec", V_DEC);
        cyc("i_exec", V_EXI);
        cyc("i_wb", V_WBALU);
        chk("i_instret", {28'd0, bus.instret}, 32'd7);

        bus.opcode = 7'b1111111;
        cyc("il_fetch", V_FRDY);
`ifdef ILLEGAL_TRAP_EN
        cyc("il_dec", V_DEC);
        cyc("il_trap1", V_TRAP);
        cyc("il_trap2", V_TRAP);
        cyc("il_trap3", V_TRAP);
        chk("il_instret", {28'd0, bus.instret}, 32'd7);
`else
        cyc("il_dec_nop", V_DECNOP);
        bus.imem_ready = 1'b0;
        cyc("il_next_fetch", V_FWAIT);
        chk("il_instret", {28'd0, bus.instret}, 32'd8);
`endif

        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.imem_ready = 1'b0;
        cyc("rf_idle", V_IDLE);
        cyc("rf_fetch1", V_FWAIT);
        reset_n = 1'b0;
        cyc("rf_fetch2", V_FWAIT);
        cyc("rf_after_rst", V_IDLE);
        chk("rf_instret", {28'd0, bus.instret}, 32'd0);
        reset_n = 1'b1;

        bus.imem_ready = 1'b1;
        bus.opcode = 7'b1100011;
        bus.branch_taken = 1'b0;
        cyc("w_idle", V_IDLE);
        for (int i = 0; i < 16; i++) begin
            cyc("w_fetch", V_FRDY);
            cyc("w_dec", V_DEC);
            cyc("w_br", V_BRNT);
            if (i == 14) chk("w_instret15", {28'd0, bus.instret}, 32'd15);
        end
        chk("w_instret_wrap", {28'd0, bus.instret}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
